// File: rtl/memory_controller.sv
//==============================================================================
// Module      : memory_controller
// Description : Control FSM for a write-back cache in front of a fixed-latency
//               main memory. A request performs a tag lookup; a miss evicts a
//               dirty victim (WRITEBACK) if needed, refills the line (FILL),
//               and then repeats the lookup once. A second miss sets a sticky
//               error flag and the access completes anyway.
//
//               Ports
//                 clk, rst          clock, asynchronous active-high reset
//                 req, req_we       access request, 1 = store / 0 = load
//                 hit, dirty_bit    tag match and victim dirty status
//                 ready             idle and accepting req
//                 done              one-cycle completion pulse
//                 cache_we          cache write enable
//                 cache_in_select   1 = requester data, 0 = memory data
//                 mem_in_select     1 = victim address, 0 = requester address
//                 mem_we, mem_re    main-memory write / read enable
//                 err               sticky: lookup after a fill still missed
//                 hit_cnt, miss_cnt saturating first-lookup statistics
//
//               MEM_LATENCY is the memory access length in cycles (1..255).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module memory_controller #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic        hit,
    input  logic        dirty_bit,
    output logic        ready,
    output logic        done,
    output logic        cache_we,
    output logic        cache_in_select,
    output logic        mem_in_select,
    output logic        mem_we,
    output logic        mem_re,
    output logic        err,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    // Counter reload value: a phase of MEM_LATENCY cycles counts
    // MEM_LATENCY-1 down to 0 inclusive.
    localparam logic [7:0]  c_LAT_M1  = 8'(MEM_LATENCY - 1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_cnt;        // cycles remaining in the current memory phase
    logic        r_retry;      // set once a fill has completed for this access
    logic        r_we;         // latched req_we for the access in flight
    logic        r_err;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    logic        w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 8'd0);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control outputs. All outputs decode from the state
    // register, so an asynchronous reset drops every enable immediately.
    // LOOKUP is Mealy on hit so that a store hit writes in the lookup cycle.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        ready           = 1'b0;
        done            = 1'b0;
        cache_we        = 1'b0;
        cache_in_select = 1'b0;
        mem_in_select   = 1'b0;
        mem_we          = 1'b0;
        mem_re          = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    w_state_next = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    if (r_we) begin
                        cache_we        = 1'b1;
                        cache_in_select = 1'b1;
                    end
                    w_state_next = S_DONE;
                end else if (r_retry) begin
                    // The refilled line still does not match: give up
                    // rather than loop on fills.
                    w_state_next = S_DONE;
                end else if (dirty_bit) begin
                    w_state_next = S_WRITEBACK;
                end else begin
                    w_state_next = S_FILL;
                end
            end

            S_WRITEBACK: begin
                mem_in_select = 1'b1;
                mem_we        = 1'b1;
                if (w_cnt_zero) begin
                    w_state_next = S_FILL;
                end
            end

            S_FILL: begin
                mem_re = 1'b1;
                // Memory data is valid only in the last fill cycle.
                if (w_cnt_zero) begin
                    cache_we     = 1'b1;
                    w_state_next = S_LOOKUP;
                end
            end

            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Access context: phase counter, retry flag, latched direction, error
    // flag and statistics.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 8'd0;
            r_retry    <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= req_we;
                        r_retry <= 1'b0;
                    end
                end

                S_LOOKUP: begin
                    // Statistics reflect only the first lookup of an access.
                    if (!r_retry) begin
                        if (hit) begin
                            if (r_hit_cnt != c_CNT_MAX) begin
                                r_hit_cnt <= r_hit_cnt + 16'd1;
                            end
                        end else begin
                            if (r_miss_cnt != c_CNT_MAX) begin
                                r_miss_cnt <= r_miss_cnt + 16'd1;
                            end
                        end
                    end
                    if (!hit) begin
                        if (r_retry) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= c_LAT_M1;
                        end
                    end
                end

                S_WRITEBACK: begin
                    if (w_cnt_zero) begin
                        r_cnt <= c_LAT_M1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                S_FILL: begin
                    if (w_cnt_zero) begin
                        r_retry <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign err      = r_err;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_memory_controller.sv
//==============================================================================
// Module      : tb_memory_controller
// Description : Self-checking bench for memory_controller. Each access is
//               described by four decisions (load/store, first-lookup hit,
//               victim dirty, re-lookup hit); the expected control outputs
//               for every cycle are derived from the access phase layout
//               (lookup, writeback, fill, re-lookup, done).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_memory_controller;

    localparam int L = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        req_we;
    logic        hit;
    logic        dirty_bit;
    logic        ready;
    logic        done;
    logic        cache_we;
    logic        cache_in_select;
    logic        mem_in_select;
    logic        mem_we;
    logic        mem_re;
    logic        err;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks;
    int failures;

    // Reference state
    int   m_hit;
    int   m_miss;
    logic m_err;

    memory_controller #(.MEM_LATENCY(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_we          (req_we),
        .hit             (hit),
        .dirty_bit       (dirty_bit),
        .ready           (ready),
        .done            (done),
        .cache_we        (cache_we),
        .cache_in_select (cache_in_select),
        .mem_in_select   (mem_in_select),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .err             (err),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, done, cache_we, cache_in_select, mem_in_select, mem_we, mem_re}
    localparam logic [6:0] c_IDLE_CTL = 7'b1000000;

    function automatic logic [6:0] ctl_obs();
        return {ready, done, cache_we, cache_in_select, mem_in_select, mem_we, mem_re};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle c of an access (cycle 1 follows the req-sampling edge) -> expected
    // control vector, from the phase layout of that access.
    function automatic logic [6:0] exp_ctl(input int c, input logic w, input logic h1,
                                           input logic d, input logic h2);
        int wb;
        int n;
        logic [6:0] v;
        wb = d ? L : 0;
        n  = h1 ? 2 : 3 + wb + L;
        v  = 7'b0;
        if (c == n) begin
            v[5] = 1'b1;
        end else if (h1) begin
            v[4] = w;
            v[3] = w;
        end else if (c == 1) begin
            v = 7'b0;
        end else if (c <= 1 + wb) begin
            v[2] = 1'b1;
            v[1] = 1'b1;
        end else if (c <= 1 + wb + L) begin
            v[0] = 1'b1;
            v[4] = (c == 1 + wb + L);
        end else begin
            v[4] = w & h2;
            v[3] = w & h2;
        end
        return v;
    endfunction

    // Runs one access; entered just after a falling edge with the DUT idle.
    task automatic run_txn(input logic w, input logic h1, input logic d, input logic h2);
        int wb;
        int n;
        int rc;
        wb = d ? L : 0;
        n  = h1 ? 2 : 3 + wb + L;
        rc = 2 + wb + L;
        chk("idle_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        req       = 1'b1;
        req_we    = w;
        hit       = h1;
        dirty_bit = d;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            // req stays high while busy: it must be ignored.
            req_we = ~w;
            hit    = (!h1 && c == rc) ? h2 : h1;
            @(negedge clk);
            chk($sformatf("ctl_c%0d_w%0d_h%0d_d%0d_r%0d", c, w, h1, d, h2),
                32'(ctl_obs()), 32'(exp_ctl(c, w, h1, d, h2)));
        end
        req = 1'b0;
        if (h1) m_hit++; else m_miss++;
        if (!h1 && !h2) m_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_idle_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        chk("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        logic w;
        logic h1;
        logic d;
        logic h2;
        checks    = 0;
        failures  = 0;
        m_hit     = 0;
        m_miss    = 0;
        m_err     = 1'b0;
        rst       = 1'b1;
        req       = 1'b0;
        req_we    = 1'b0;
        hit       = 1'b0;
        dirty_bit = 1'b0;

        // Reset state, before any clock edge
        #1;
        chk("rst_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed: load hit, store hit, clean load miss, dirty store miss
        run_txn(1'b0, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1);
        run_txn(1'b0, 1'b0, 1'b0, 1'b1);
        run_txn(1'b1, 1'b0, 1'b1, 1'b1);
        // Persistent miss: one fill, sticky err
        run_txn(1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized accesses
        for (int i = 0; i < 24; i++) begin
            w  = 1'($urandom_range(0, 1));
            h1 = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            h2 = ($urandom_range(0, 3) != 0);
            run_txn(w, h1, d, h2);
        end

        // Reset during the second writeback cycle of a dirty miss
        chk("pre_abort_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        req       = 1'b1;
        req_we    = 1'b0;
        hit       = 1'b0;
        dirty_bit = 1'b1;
        @(posedge clk);   // sampling edge
        #1;
        req = 1'b0;
        @(posedge clk);   // into WRITEBACK
        @(posedge clk);   // second WRITEBACK cycle
        #2;
        chk("abort_pre_mem_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_held_ctl", 32'(ctl_obs()), 32'(c_IDLE_CTL));
        @(negedge clk);
        rst    = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        m_err  = 1'b0;
        run_txn(1'b0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
